// File: rtl/interrupt_acknowledge_sequencer.sv
// interrupt_acknowledge_sequencer: raises INT, runs the two-pulse 8086 INTA# cycle, maintains the ISR and drives the vector byte.
// Define PIC_AUTO_EOI_EN to let auto_eoi_config retire the in-service bit on the second INTA# rise.
module interrupt_acknowledge_sequencer #(
    parameter int NUM_LEVELS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_LEVELS-1:0] interrupt,
    input  logic                  interrupt_acknowledge_n,
    input  logic [2:0]            priority_rotate,
    input  logic [4:0]            vector_base,
    input  logic [NUM_LEVELS-1:0] end_of_interrupt,
    input  logic                  auto_eoi_config,
    output logic                  interrupt_to_cpu,
    output logic [NUM_LEVELS-1:0] in_service_register,
    output logic [NUM_LEVELS-1:0] highest_in_service,
    output logic [NUM_LEVELS-1:0] clear_interrupt_request,
    output logic [7:0]            data_out,
    output logic                  data_out_enable
);

    typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

    localparam logic [NUM_LEVELS-1:0] ONE = 1;

    state_t                state_q, state_d;
    logic                  inta_prev_q;
    logic [2:0]            ack_level_q, ack_level_d;
    logic                  ack_valid_q, ack_valid_d;
    logic                  int_q, int_d;
    logic [NUM_LEVELS-1:0] isr_q, isr_d;
    logic [NUM_LEVELS-1:0] clr_q, clr_d;
    logic [7:0]            dout_q, dout_d;
    logic                  doe_q, doe_d;
    logic [NUM_LEVELS-1:0] set_mask, aeoi_mask;
    logic [2:0]            req_level, idx;
    logic                  fall, rise;

    assign fall = inta_prev_q & ~interrupt_acknowledge_n;
    assign rise = ~inta_prev_q & interrupt_acknowledge_n;

`ifdef PIC_AUTO_EOI_EN
`else
    logic unused_auto_eoi;
    assign unused_auto_eoi = auto_eoi_config;
`endif

    // Encode the winning request; with no request the spurious level 7 is used.
    always_comb begin
        req_level = 3'd7;
        for (int i = NUM_LEVELS - 1; i >= 0; i--)
            if (interrupt[i]) req_level = 3'(i);
    end

    // Acknowledge sequencer: next state, latched level, INT and data bus drive.
    always_comb begin
        state_d     = state_q;
        ack_level_d = ack_level_q;
        ack_valid_d = ack_valid_q;
        int_d       = 1'b0;
        dout_d      = dout_q;
        doe_d       = doe_q;
        set_mask    = '0;
        aeoi_mask   = '0;
        case (state_q)
            IDLE: begin
                int_d = |interrupt;
                if (fall) begin
                    state_d     = ACK1;
                    int_d       = 1'b0;
                    ack_level_d = req_level;
                    ack_valid_d = |interrupt;
                    set_mask    = |interrupt ? ONE << req_level : '0;
                end
            end
            ACK1: state_d = rise ? WAIT2 : ACK1;
            WAIT2: begin
                if (fall) begin
                    state_d = ACK2;
                    dout_d  = {vector_base, ack_level_q};
                    doe_d   = 1'b1;
                end
            end
            ACK2: begin
                if (rise) begin
                    state_d = IDLE;
                    doe_d   = 1'b0;
`ifdef PIC_AUTO_EOI_EN
                    aeoi_mask = (auto_eoi_config && ack_valid_q) ? ONE << ack_level_q : '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ISR update: clears first, then a same-cycle set wins; the IRR clear mirrors the set.
    always_comb begin
        isr_d = (isr_q & ~(end_of_interrupt | aeoi_mask)) | set_mask;
        clr_d = set_mask;
    end

    // Highest in-service level: scan from lowest to highest priority so the last hit wins.
    always_comb begin
        highest_in_service = '0;
        idx                = 3'd0;
        for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
            idx = priority_rotate + 3'(i) + 3'd1;
            if (isr_q[idx]) highest_in_service = ONE << idx;
        end
    end

    // State and output registers; reset aborts any sequence in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            inta_prev_q <= 1'b1;
            ack_level_q <= 3'd0;
            ack_valid_q <= 1'b0;
            int_q       <= 1'b0;
            isr_q       <= '0;
            clr_q       <= '0;
            dout_q      <= 8'd0;
            doe_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            inta_prev_q <= interrupt_acknowledge_n;
            ack_level_q <= ack_level_d;
            ack_valid_q <= ack_valid_d;
            int_q       <= int_d;
            isr_q       <= isr_d;
            clr_q       <= clr_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
        end
    end

    assign interrupt_to_cpu        = int_q;
    assign in_service_register     = isr_q;
    assign clear_interrupt_request = clr_q;
    assign data_out                = dout_q;
    assign data_out_enable         = doe_q;

endmodule

// File: doc/interrupt_acknowledge_sequencer.md
Name: interrupt_acknowledge_sequencer

Overview:
- CPU-side counterpart of the priority resolver. Takes the one-hot winning request, raises INT to the CPU and runs the two-pulse 8086-mode INTA# cycle.
- On acknowledge it sets the in-service bit, requests the IRR bit clear and drives the vector byte on the data bus.
- Retires in-service bits on EOI, and also on auto-EOI when that feature is compiled in.
- Feeds in_service_register and highest_in_service back to the resolver.

Parameters:
- NUM_LEVELS, 8, number of interrupt levels. Fixed at 8; no other value is supported.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- interrupt  in  8  one-hot winning request from the resolver (0 = none)
- interrupt_acknowledge_n  in  1  CPU INTA#, already synchronized to clock
- priority_rotate  in  3  current lowest-priority level
- vector_base  in  5  ICW2 T7..T3
- end_of_interrupt  in  8  one-cycle clear mask from the command decoder
- auto_eoi_config  in  1  AEOI mode, from ICW4
- interrupt_to_cpu  out  1  INT pin
- in_service_register  out  8  ISR
- highest_in_service  out  8  one-hot highest-priority ISR bit
- clear_interrupt_request  out  8  one-cycle IRR clear pulse
- data_out  out  8  vector byte
- data_out_enable  out  1  data bus drive enable

Behaviour:
- Reset: asynchronous, active-high.
  - Outputs: interrupt_to_cpu=0, in_service_register=0, clear_interrupt_request=0, data_out=0, data_out_enable=0.
  - Internal: state=IDLE, inta_prev=1, ack_level=0, ack_valid=0.
  - Reset mid-sequence aborts the sequence; the next cycle starts clean in IDLE.
- Edge detection:
  - fall = inta_prev & ~interrupt_acknowledge_n
  - rise = ~inta_prev & interrupt_acknowledge_n
  - inta_prev is updated every cycle.
- FSM states: IDLE, ACK1, WAIT2, ACK2.
  - IDLE:
    - interrupt_to_cpu <= |interrupt (registered, 1-cycle latency).
    - On fall: go to ACK1; interrupt_to_cpu <= 0; ack_level <= encode(interrupt); ack_valid <= |interrupt.
    - If ack_valid: set ISR[ack_level] and pulse clear_interrupt_request bit ack_level for exactly one cycle (next cycle).
    - If interrupt==0 at fall (spurious): ack_level=7, ack_valid=0, ISR unchanged, no clear pulse.
  - ACK1: on rise -> WAIT2. data_out_enable stays 0 (first pulse carries no data).
  - WAIT2: on fall -> ACK2; data_out <= {vector_base, ack_level}; data_out_enable <= 1.
  - ACK2:
    - data_out_enable held 1 while INTA# low.
    - On rise -> IDLE; data_out_enable <= 0; data_out holds its last value.
    - Auto-EOI clear is applied here (see Optional Feature).
  - interrupt_to_cpu is 0 in ACK1, WAIT2 and ACK2; it is re-evaluated from IDLE the cycle after return.
- ISR update, per bit, same cycle:
  - next = (ISR & ~eoi_clear) | set
  - eoi_clear = end_of_interrupt OR the auto-EOI clear.
  - Set wins over clear on the same bit.
- highest_in_service: combinational from the registered ISR.
  - Search order starts at (priority_rotate+1) mod 8 and wraps through priority_rotate.
  - Result is one-hot; 0 if ISR==0.
  - priority_rotate=7 gives fixed priority, IR0 highest.
- Changes on interrupt during ACK1/WAIT2/ACK2 are ignored; the level is frozen at the first fall.
- A fall while in ACK1 (glitch, rise not yet seen) is ignored.

Optional Feature:
- Macro: PIC_AUTO_EOI_EN.
- Defined: when auto_eoi_config=1, the ACK2 rise clears ISR[ack_level] in the same cycle as the IDLE transition, provided ack_valid=1.
- Not defined: auto_eoi_config is ignored; ISR bits clear only via end_of_interrupt.

Test Plan:
- Reset released, interrupt=8'h04, vector_base=5'b00001, two INTA# pulses:
  - interrupt_to_cpu=1 one cycle later, then 0 after the first fall.
  - ISR=8'h04; clear_interrupt_request=8'h04 for one cycle.
  - Second pulse: data_out=8'h0A, data_out_enable=1 only while INTA# low.
- ISR=8'h14, priority_rotate=7 -> highest_in_service=8'h04. Then priority_rotate=3 -> 8'h10.
- end_of_interrupt=8'h04 in the same cycle a new ack sets bit 2 -> ISR bit 2 remains 1. A later end_of_interrupt=8'h04 alone -> bit 2 cleared.
- Spurious case, interrupt=0 at first fall, vector_base=5'b00010 -> ISR unchanged, no clear pulse, data_out=8'h17.
- Reset asserted during WAIT2 -> all outputs 0 immediately. A subsequent clean sequence with interrupt=8'h01 gives vector {vector_base,3'd0}.
- With PIC_AUTO_EOI_EN defined and auto_eoi_config=1, interrupt=8'h80 -> ISR=8'h80 after the first pulse, 8'h00 after the second rise. Without the macro it stays 8'h80.
